rect_pos_arbiter: RTL and testbench
===================================

// Module: rect_pos_arbiter
// PURPOSE
// - Shares the position inputs (x, y) of the rectangle drawer between two requesters (A, B).
// - Requesters are e.g. the mouse path and the keyboard/auto-move path.
// - Round-robin arbitration; a granted position is committed only at a frame boundary
//   (rising edge of vblnk), so the rectangle never tears mid-frame.
// - Sits between the control sources and the drawer's x/y inputs. Its vblnk comes from the timing chain.
// PARAMETERS
// - W        100  rectangle width in pixels (used by clamp)
// - H        100  rectangle height in pixels (used by clamp)
// - SCREEN_W 800  visible width in pixels
// - SCREEN_H 600  visible height in pixels
// - X_RST    0    x value after reset
// - Y_RST    0    y value after reset
// PORTS
// - clk        in   1   pixel clock
// - rst        in   1   reset: synchronous, active-high
// - vblnk      in   1   vertical blank from the timing chain
// - req_a      in   1   A requests a position update; level, held until ack_a
// - x_a        in   12  A requested x; stable while req_a is high
// - y_a        in   12  A requested y; stable while req_a is high
// - ack_a      out  1   1-cycle pulse: A's position is committed
// - req_b      in   1   as req_a, for requester B
// - x_b        in   12  as x_a, for B
// - y_b        in   12  as y_a, for B
// - ack_b      out  1   as ack_a, for B
// - x          out  12  committed rectangle x, to the drawer
// - y          out  12  committed rectangle y, to the drawer
// - frame_tick out  1   1-cycle pulse on the vblnk rising edge (registered)
// - busy       out  1   high while state != IDLE
// BEHAVIOUR
// - Reset values:
//   - x = X_RST, y = Y_RST.
//   - ack_a = ack_b = 0, frame_tick = 0, busy = 0.
//   - state = IDLE; last_grant = B, so A wins the first tie.
//   - vblnk_d = 0.
// - Edge detect: vblnk_d <= vblnk; tick = vblnk & ~vblnk_d. frame_tick <= tick (1-cycle latency).
// - FSM states: IDLE, PENDING, DONE.
// - IDLE:
//   - Only one of req_a/req_b high: grant it.
//   - Both high: grant the one that is not last_grant.
//   - On grant: latch pend_x/pend_y from the granted requester, store pend_src, last_grant <= grantee,
//     state -> PENDING.
//   - A tick in the grant cycle is ignored; the commit waits for the next tick.
// - PENDING:
//   - On tick: x <= pend_x, y <= pend_y, and ack of pend_src <= 1 (registered, visible the next cycle).
//     State -> DONE.
//   - No tick: hold. Changes on req/x/y inputs are ignored because the data is already latched.
// - DONE: lasts one cycle. The ack is high, acks clear next cycle, no arbitration. State -> IDLE.
//   The requester must drop req on the cycle ack is seen; a req still high in IDLE is a new request.
// - Throughput: at most one commit per frame. A request losing a tie is served on the following frame.
// - x/y change only in the PENDING+tick cycle. Between commits they are constant.
// - ack_a and ack_b are never high together; each ack pulse is exactly 1 cycle.
// - Requester drops req before ack while in PENDING: the latched request still commits and ack
//   still pulses.
// - vblnk high at reset release: no tick until vblnk falls and rises again.
// - Reset mid-operation (PENDING or DONE):
//   - The pending request is discarded with no ack; x/y return to X_RST/Y_RST.
// - Coordinates are 12-bit unsigned with no arithmetic, except the clamp below.
// CONFIGURATION
// - RECT_POS_CLAMP_EN defined:
//   - pend_x = min(x_req, SCREEN_W-W) and pend_y = min(y_req, SCREEN_H-H), applied at latch time.
//   - The comparison is 12-bit unsigned, so the rectangle always stays fully on screen.
// - RECT_POS_CLAMP_EN undefined: requested x/y are latched unmodified, and off-screen values pass through.
// TESTING
// - Reset: assert rst 3 cycles -> x=0, y=0, ack_a=ack_b=0, busy=0.
// - Single A request: req_a=1, x_a=200, y_a=150.
//   - -> busy=1, x/y unchanged until the vblnk rise.
//   - On the tick: x=200, y=150 one cycle later, ack_a pulses exactly 1 cycle.
// - Tie: req_a and req_b both high from reset.
//   - -> A committed on frame 1, B committed on frame 2. Never two commits in one frame.
//   - Next tie -> A, because round-robin alternates with last_grant.
// - Input change while PENDING: x_a changes 200->300 after the grant -> 200 is committed.
// - Clamp, with RECT_POS_CLAMP_EN defined, defaults: x_b=780, y_b=590 -> x=700, y=500.
//   The same stimulus without the macro -> x=780, y=590.
// - Reset mid-PENDING: grant B, assert rst before the tick -> no ack_b, x=X_RST, y=Y_RST, state=IDLE.

Source files
------------

// File: rtl/rect_pos_arbiter.sv
// Round-robin arbiter sharing the rectangle position between two requesters; commits on vblnk rise.
// Optional clamp to keep the rectangle on screen: define RECT_POS_CLAMP_EN.
module rect_pos_arbiter #(
    parameter int unsigned W        = 100,
    parameter int unsigned H        = 100,
    parameter int unsigned SCREEN_W = 800,
    parameter int unsigned SCREEN_H = 600,
    parameter logic [11:0] X_RST    = 12'd0,
    parameter logic [11:0] Y_RST    = 12'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        req_a,
    input  logic [11:0] x_a,
    input  logic [11:0] y_a,
    output logic        ack_a,
    input  logic        req_b,
    input  logic [11:0] x_b,
    input  logic [11:0] y_b,
    output logic        ack_b,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        frame_tick,
    output logic        busy
);

`ifdef RECT_POS_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    localparam logic [11:0] X_MAX = 12'(SCREEN_W - W);
    localparam logic [11:0] Y_MAX = 12'(SCREEN_H - H);

    typedef enum logic [1:0] {StIdle, StPending, StDone} state_e;

    state_e      state;
    logic        vblnk_d;
    logic        seen_low;
    logic        last_grant;  // 0 = A, 1 = B
    logic        pend_src;
    logic [11:0] pend_x;
    logic [11:0] pend_y;

    logic        tick;
    logic        gnt_a;
    logic        gnt_b;
    logic [11:0] sel_x;
    logic [11:0] sel_y;
    logic [11:0] lim_x;
    logic [11:0] lim_y;

    // seen_low keeps a vblnk already high at reset release from looking like a rising edge
    assign tick = vblnk & ~vblnk_d & seen_low;

    assign gnt_a = req_a & (~req_b | last_grant);
    assign gnt_b = req_b & (~req_a | ~last_grant);

    assign sel_x = gnt_a ? x_a : x_b;
    assign sel_y = gnt_a ? y_a : y_b;
    assign lim_x = (CLAMP_EN && (sel_x > X_MAX)) ? X_MAX : sel_x;
    assign lim_y = (CLAMP_EN && (sel_y > Y_MAX)) ? Y_MAX : sel_y;

    assign busy = (state != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            vblnk_d    <= 1'b0;
            seen_low   <= 1'b0;
            last_grant <= 1'b1;
            pend_src   <= 1'b0;
            pend_x     <= X_RST;
            pend_y     <= Y_RST;
            x          <= X_RST;
            y          <= Y_RST;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vblnk_d    <= vblnk;
            frame_tick <= tick;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
            if (!vblnk) begin
                seen_low <= 1'b1;
            end
            case (state)
                StIdle: begin
                    if (gnt_a || gnt_b) begin
                        pend_x     <= lim_x;
                        pend_y     <= lim_y;
                        pend_src   <= gnt_b;
                        last_grant <= gnt_b;
                        state      <= StPending;
                    end
                end
                StPending: begin
                    if (tick) begin
                        x     <= pend_x;
                        y     <= pend_y;
                        ack_a <= ~pend_src;
                        ack_b <= pend_src;
                        state <= StDone;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rect_pos_arbiter.sv
// Directed, table-driven bench for rect_pos_arbiter: one row per clock cycle, then a
// free-running frame sequence checking that a held request is acked exactly once.
module tb_rect_pos_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vblnk = 1'b0;
    logic        req_a = 1'b0;
    logic [11:0] x_a = '0;
    logic [11:0] y_a = '0;
    logic        ack_a;
    logic        req_b = 1'b0;
    logic [11:0] x_b = '0;
    logic [11:0] y_b = '0;
    logic        ack_b;
    logic [11:0] x;
    logic [11:0] y;
    logic        frame_tick;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    rect_pos_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .vblnk     (vblnk),
        .req_a     (req_a),
        .x_a       (x_a),
        .y_a       (y_a),
        .ack_a     (ack_a),
        .req_b     (req_b),
        .x_b       (x_b),
        .y_b       (y_b),
        .ack_b     (ack_b),
        .x         (x),
        .y         (y),
        .frame_tick(frame_tick),
        .busy      (busy)
    );

    always #5 clk = ~clk;

`ifdef RECT_POS_CLAMP_EN
    localparam logic [11:0] CLX = 12'd700;
    localparam logic [11:0] CLY = 12'd500;
`else
    localparam logic [11:0] CLX = 12'd780;
    localparam logic [11:0] CLY = 12'd590;
`endif

    typedef struct {
        logic        rst;
        logic        vblnk;
        logic        req_a;
        logic [11:0] x_a;
        logic [11:0] y_a;
        logic        req_b;
        logic [11:0] x_b;
        logic [11:0] y_b;
        logic [11:0] ex;
        logic [11:0] ey;
        logic        eack_a;
        logic        eack_b;
        logic        ebusy;
        logic        etick;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic ra, input int xa, input int ya,
                       input logic rb, input int xb, input int yb, input int ex, input int ey,
                       input logic aa, input logic ab, input logic bz, input logic ft);
        vec_t t;
        t.rst = r;   t.vblnk = v;  t.req_a = ra; t.x_a = 12'(xa); t.y_a = 12'(ya);
        t.req_b = rb; t.x_b = 12'(xb); t.y_b = 12'(yb);
        t.ex = 12'(ex); t.ey = 12'(ey);
        t.eack_a = aa; t.eack_b = ab; t.ebusy = bz; t.etick = ft;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int row, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s row %0d: got %0d, expected %0d", name, row, act, exp);
    endtask

    initial begin
        int acks;
        int ack_x;
        int ack_y;

        //   rst v  ra xa   ya   rb xb   yb    x    y    aa ab bz ft
        add(1, 0, 0, 0,   0,   0, 0,   0,    0,   0,   0, 0, 0, 0);  // reset
        add(1, 0, 0, 0,   0,   0, 0,   0,    0,   0,   0, 0, 0, 0);
        add(1, 0, 0, 0,   0,   0, 0,   0,    0,   0,   0, 0, 0, 0);
        add(0, 0, 1, 200, 150, 0, 0,   0,    0,   0,   0, 0, 1, 0);  // single A grant
        add(0, 0, 1, 200, 150, 0, 0,   0,    0,   0,   0, 0, 1, 0);
        add(0, 1, 1, 200, 150, 0, 0,   0,    200, 150, 1, 0, 1, 1);  // commit
        add(0, 1, 0, 200, 150, 0, 0,   0,    200, 150, 0, 0, 0, 0);
        add(0, 0, 0, 200, 150, 0, 0,   0,    200, 150, 0, 0, 0, 0);
        add(0, 0, 1, 300, 40,  0, 0,   0,    200, 150, 0, 0, 1, 0);  // latch 300,40
        add(0, 0, 1, 333, 77,  0, 0,   0,    200, 150, 0, 0, 1, 0);  // input change ignored
        add(0, 1, 1, 333, 77,  0, 0,   0,    300, 40,  1, 0, 1, 1);
        add(0, 1, 0, 333, 77,  0, 0,   0,    300, 40,  0, 0, 0, 0);
        add(1, 1, 0, 0,   0,   0, 0,   0,    0,   0,   0, 0, 0, 0);  // reset before tie
        add(0, 0, 1, 10,  20,  1, 30,  40,   0,   0,   0, 0, 1, 0);  // tie -> A
        add(0, 1, 1, 10,  20,  1, 30,  40,   10,  20,  1, 0, 1, 1);
        add(0, 1, 0, 10,  20,  1, 30,  40,   10,  20,  0, 0, 0, 0);
        add(0, 1, 0, 10,  20,  1, 30,  40,   10,  20,  0, 0, 1, 0);  // B granted, waits frame
        add(0, 0, 0, 10,  20,  1, 30,  40,   10,  20,  0, 0, 1, 0);
        add(0, 1, 0, 10,  20,  1, 30,  40,   30,  40,  0, 1, 1, 1);
        add(0, 1, 0, 10,  20,  0, 30,  40,   30,  40,  0, 0, 0, 0);
        add(0, 0, 1, 50,  60,  1, 70,  80,   30,  40,  0, 0, 1, 0);  // next tie -> A
        add(0, 1, 1, 50,  60,  1, 70,  80,   50,  60,  1, 0, 1, 1);
        add(0, 0, 0, 50,  60,  1, 70,  80,   50,  60,  0, 0, 0, 0);
        add(0, 0, 0, 50,  60,  1, 70,  80,   50,  60,  0, 0, 1, 0);
        add(0, 1, 0, 50,  60,  1, 70,  80,   70,  80,  0, 1, 1, 1);
        add(0, 0, 0, 50,  60,  0, 70,  80,   70,  80,  0, 0, 0, 0);
        add(0, 1, 0, 0,   0,   1, 780, 590,  70,  80,  0, 0, 1, 1);  // tick in grant cycle
        add(0, 1, 0, 0,   0,   1, 780, 590,  70,  80,  0, 0, 1, 0);
        add(0, 0, 0, 0,   0,   1, 780, 590,  70,  80,  0, 0, 1, 0);
        add(0, 1, 0, 0,   0,   1, 780, 590,  CLX, CLY, 0, 1, 1, 1);  // clamp / pass-through
        add(0, 0, 0, 0,   0,   0, 780, 590,  CLX, CLY, 0, 0, 0, 0);
        add(0, 0, 0, 0,   0,   1, 5,   6,    CLX, CLY, 0, 0, 1, 0);  // B pending
        add(1, 0, 0, 0,   0,   0, 5,   6,    0,   0,   0, 0, 0, 0);  // reset discards it
        add(0, 1, 0, 0,   0,   0, 5,   6,    0,   0,   0, 0, 0, 0);  // vblnk high at release
        add(0, 1, 1, 9,   9,   0, 0,   0,    0,   0,   0, 0, 1, 0);
        add(0, 0, 1, 9,   9,   0, 0,   0,    0,   0,   0, 0, 1, 0);
        add(0, 1, 1, 9,   9,   0, 0,   0,    9,   9,   1, 0, 1, 1);
        add(0, 1, 0, 9,   9,   0, 0,   0,    9,   9,   0, 0, 0, 0);
        add(0, 0, 1, 11,  12,  0, 0,   0,    9,   9,   0, 0, 1, 0);  // req dropped in PENDING
        add(0, 0, 0, 11,  12,  0, 0,   0,    9,   9,   0, 0, 1, 0);
        add(0, 1, 0, 11,  12,  0, 0,   0,    11,  12,  1, 0, 1, 1);
        add(0, 0, 0, 11,  12,  0, 0,   0,    11,  12,  0, 0, 0, 0);

        foreach (vecs[i]) begin
            rst   = vecs[i].rst;
            vblnk = vecs[i].vblnk;
            req_a = vecs[i].req_a;
            x_a   = vecs[i].x_a;
            y_a   = vecs[i].y_a;
            req_b = vecs[i].req_b;
            x_b   = vecs[i].x_b;
            y_b   = vecs[i].y_b;
            @(posedge clk);
            #1;
            check("x", i, int'(x), int'(vecs[i].ex));
            check("y", i, int'(y), int'(vecs[i].ey));
            check("ack_a", i, int'(ack_a), int'(vecs[i].eack_a));
            check("ack_b", i, int'(ack_b), int'(vecs[i].eack_b));
            check("busy", i, int'(busy), int'(vecs[i].ebusy));
            check("frame_tick", i, int'(frame_tick), int'(vecs[i].etick));
        end

        // Held B request across free-running frames: exactly one ack, correct data, then idle.
        acks  = 0;
        ack_x = -1;
        ack_y = -1;
        req_b = 1'b1;
        x_b   = 12'd123;
        y_b   = 12'd321;
        for (int i = 0; i < 40; i++) begin
            vblnk = ((i % 8) >= 4);
            @(posedge clk);
            #1;
            if (ack_a) acks += 100;
            if (ack_b) begin
                acks++;
                ack_x = int'(x);
                ack_y = int'(y);
                req_b = 1'b0;
            end
        end
        check("seq_ack_count", 100, acks, 1);
        check("seq_ack_x", 100, ack_x, 123);
        check("seq_ack_y", 100, ack_y, 321);
        check("seq_idle", 100, int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
